serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder that drives the existing 1-bit fulladder cell one bit per clock.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fulladder.sv | 14 +
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// The adder runs its operands one bit per clock through a full-adder cell.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    // The counter is wide enough to hold WIDTH, so WIDTH=1 never needs a zero-width counter.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit combinational full-adder cell.
// The serial adder steps this cell once per clock.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Cout,
    output logic S
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are shifted LSB-first through the fulladder cell.
// A start/busy/done handshake controls each operation, and the result is held until the next one completes.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on an accepted start
//   RUN   | one operand bit per clock through the cell, WIDTH clocks
//   DONE  | one-cycle done pulse; sum/cout already valid
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] s_sh_d;

    fulladder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .Cout (fa_cout),
        .S    (fa_s)
    );

    // The bit that would shift out of the partial-sum register is never read,
    // so only the upper WIDTH-1 bits are stored.
    generate
        if (WIDTH > 1) begin : g_sh
            logic [WIDTH-2:0] s_sh_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_sh_q <= '0;
                end else if (state_q == RUN) begin
                    s_sh_q <= s_sh_d[WIDTH-1:1];
                end
            end

            assign s_sh_d = {fa_s, s_sh_q};
        end else begin : g_sh1
            assign s_sh_d = fa_s;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= fa_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances, vector table plus hand-built sequences.
// Expected results queue up at start and are checked when done pulses.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s8, c8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       s1, c1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt8 = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each done pulse consumes the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            done_cnt8++;
            if (q8.size() == 0) begin
                chk("unexpected_done8", {23'd0, cout8, sum8}, 32'h1ff);
            end else begin
                chk("result8", {23'd0, cout8, sum8}, {23'd0, q8.pop_front()});
            end
        end
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", {30'd0, cout1, sum1}, 32'h3);
            end else begin
                chk("result1", {30'd0, cout1, sum1}, {30'd0, q1.pop_front()});
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int n;
        int nb;
        @(negedge clk);
        a8 = a; b8 = b; c8 = ci; s8 = 1'b1;
        q8.push_back(9'(a) + 9'(b) + 9'(ci));
        @(negedge clk);
        s8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        n  = 0;
        nb = busy8 ? 1 : 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy8) nb++;
        end
        chk("latency8", n, 8);
        chk("busy_cycles8", nb, 9);
        @(negedge clk);
    endtask

    task automatic run1(input logic a, input logic b, input logic ci);
        int n;
        int nb;
        @(negedge clk);
        a1 = a; b1 = b; c1 = ci; s1 = 1'b1;
        q1.push_back(2'(a) + 2'(b) + 2'(ci));
        @(negedge clk);
        s1 = 1'b0;
        a1 = ~a1; b1 = ~b1; c1 = ~c1;
        n  = 0;
        nb = busy1 ? 1 : 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
            if (busy1) nb++;
        end
        chk("latency1", n, 1);
        chk("busy_cycles1", nb, 2);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   d0;
        int   n;
        int   dk[$];
        logic [7:0] held, ka, kb;
        logic       kc;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[5] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0};

        rst_n = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        s1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        #2;
        chk("reset_busy8", busy8, 1'b0);
        chk("reset_done8", done8, 1'b0);
        chk("reset_sum8", sum8, 8'h00);
        chk("reset_cout8", cout8, 1'b0);
        chk("reset_busy1", busy1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Vector table: result is checked by the scoreboard against the table entry too.
        for (int i = 0; i < 6; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin);
            chk("vec_sum", sum8, vecs[i].sum);
            chk("vec_cout", cout8, vecs[i].cout);
        end
        for (int i = 0; i < 6; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // start pulsed during RUN must be ignored
        d0 = done_cnt8;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; s8 = 1'b1;
        q8.push_back(9'h030);
        @(negedge clk);
        s8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("ignored_start_sum", sum8, 8'h30);
        chk("ignored_start_pulses", done_cnt8 - d0, 1);
        chk("ignored_start_idle", busy8, 1'b0);

        // Reset after four bits aborts immediately, with no done afterwards.
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b1; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done_cnt8;
        #2;
        rst_n = 1'b0;
        q8.delete();
        #1;
        chk("abort_busy", busy8, 1'b0);
        chk("abort_done", done8, 1'b0);
        chk("abort_sum", sum8, 8'h00);
        chk("abort_cout", cout8, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_done", done_cnt8 - d0, 0);
        chk("abort_idle", busy8, 1'b0);

        // start held high: one accept per IDLE visit, every 10 cycles
        held = sum8;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done8) begin
                dk.push_back(k);
                held = sum8;
            end else begin
                chk("held_sum_stable", sum8, held);
            end
            ka = 8'(k * 7 + 3);
            kb = 8'(k * 13 + 5);
            kc = 1'(k % 2);
            a8 = ka; b8 = kb; c8 = kc; s8 = 1'b1;
            if (k % 10 == 0) q8.push_back(9'(ka) + 9'(kb) + 9'(kc));
        end
        @(negedge clk);
        s8 = 1'b0;
        chk("held_done_count", dk.size(), 3);
        if (dk.size() == 3) begin
            chk("held_spacing_1", dk[1] - dk[0], 10);
            chk("held_spacing_2", dk[2] - dk[1], 10);
        end
        repeat (12) @(negedge clk);
        chk("held_queue_empty", q8.size(), 0);

        // WIDTH=1, all operand combinations
        for (int i = 0; i < 8; i++) begin
            run1(i[2], i[1], i[0]);
        end
        chk("w1_queue_empty", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
